// File: rtl/rx_mac.sv
// rx_mac: receive-side GMII MAC.
// Removes the preamble and SFD, forwards the frame body without the FCS, checks the CRC-32 and
// the frame length, and reports status for each frame. Saturating good/bad frame counters are kept.
//
// Ports
//   RX_CLK, SYS_RST_N               receive clock; asynchronous active-low reset
//   GMII_RXD/GMII_RX_DV/GMII_RX_ER  GMII receive bus (registered once on entry)
//   RX_DATA/RX_VALID/RX_LAST        frame byte stream, FCS stripped, no backpressure
//   RX_GOOD/RX_BAD                  one-cycle end-of-frame status pulses
//   RX_ERR                          [0] CRC, [1] length, [2] GMII_RX_ER seen
//   RX_LEN                          byte count after SFD including FCS
//   RX_BUSY                         receiver is inside a preamble, frame or drop
//   FRAMES_OK/FRAMES_BAD            saturating status counters
module rx_mac #(
    parameter int unsigned MIN_FRAME_LENGTH = 64,
    parameter int unsigned MAX_FRAME_LENGTH = 1518
) (
    input  logic        RX_CLK,
    input  logic        SYS_RST_N,
    input  logic [7:0]  GMII_RXD,
    input  logic        GMII_RX_DV,
    input  logic        GMII_RX_ER,
    output logic [7:0]  RX_DATA,
    output logic        RX_VALID,
    output logic        RX_LAST,
    output logic        RX_GOOD,
    output logic        RX_BAD,
    output logic [2:0]  RX_ERR,
    output logic [15:0] RX_LEN,
    output logic        RX_BUSY,
    output logic [15:0] FRAMES_OK,
    output logic [15:0] FRAMES_BAD
);

    localparam logic [31:0] CrcPoly    = 32'hEDB88320;
    localparam logic [31:0] CrcInit    = 32'hFFFFFFFF;
    localparam logic [31:0] CrcResidue = 32'hDEBB20E3;
    localparam logic [15:0] MinLen     = 16'(MIN_FRAME_LENGTH);
    localparam logic [15:0] AbortLen   = 16'(MAX_FRAME_LENGTH + 1);
    localparam logic [7:0]  Preamble   = 8'h55;
    localparam logic [7:0]  Sfd        = 8'hD5;

    typedef enum logic [1:0] {StIdle, StPreamble, StData, StDrop} state_e;

    // Reflected CRC-32 update over one byte, LSB first.
    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc ^ {24'h000000, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CrcPoly) : (c >> 1);
        end
        return c;
    endfunction

    // Input stage
    logic [7:0] rxd_q;
    logic       dv_q, er_q;

    state_e          state_q, state_d;
    logic [15:0]     len_q, len_d;
    logic [31:0]     crc_q, crc_d;
    logic            er_flag_q, er_flag_d;
    // Delay line: slot 0 is the newest byte and slot 4 is the oldest. When the frame ends,
    // slots 0..3 hold the FCS.
    logic [4:0][7:0] dly_q, dly_d;

    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        rx_last_q, rx_last_d;
    logic        rx_good_q, rx_good_d;
    logic        rx_bad_q, rx_bad_d;
    logic [2:0]  rx_err_q, rx_err_d;
    logic [15:0] rx_len_q, rx_len_d;
    logic [15:0] frames_ok_q, frames_ok_d;
    logic [15:0] frames_bad_q, frames_bad_d;

    logic [2:0]  end_err;

    always_ff @(posedge RX_CLK or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            rxd_q        <= 8'h00;
            dv_q         <= 1'b0;
            er_q         <= 1'b0;
            state_q      <= StIdle;
            len_q        <= 16'h0000;
            crc_q        <= CrcInit;
            er_flag_q    <= 1'b0;
            dly_q        <= '0;
            rx_data_q    <= 8'h00;
            rx_valid_q   <= 1'b0;
            rx_last_q    <= 1'b0;
            rx_good_q    <= 1'b0;
            rx_bad_q     <= 1'b0;
            rx_err_q     <= 3'b000;
            rx_len_q     <= 16'h0000;
            frames_ok_q  <= 16'h0000;
            frames_bad_q <= 16'h0000;
        end else begin
            rxd_q        <= GMII_RXD;
            dv_q         <= GMII_RX_DV;
            er_q         <= GMII_RX_ER;
            state_q      <= state_d;
            len_q        <= len_d;
            crc_q        <= crc_d;
            er_flag_q    <= er_flag_d;
            dly_q        <= dly_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            rx_last_q    <= rx_last_d;
            rx_good_q    <= rx_good_d;
            rx_bad_q     <= rx_bad_d;
            rx_err_q     <= rx_err_d;
            rx_len_q     <= rx_len_d;
            frames_ok_q  <= frames_ok_d;
            frames_bad_q <= frames_bad_d;
        end
    end

    assign end_err = {er_flag_q, (len_q < MinLen), (crc_q != CrcResidue)};

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        crc_d      = crc_q;
        er_flag_d  = er_flag_q;
        dly_d      = dly_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_last_d  = 1'b0;
        rx_good_d  = 1'b0;
        rx_bad_d   = 1'b0;
        rx_err_d   = rx_err_q;
        rx_len_d   = rx_len_q;

        unique case (state_q)
            StIdle: begin
                if (dv_q) begin
                    state_d = (rxd_q == Preamble) ? StPreamble : StDrop;
                end
            end
            StPreamble: begin
                if (!dv_q) begin
                    state_d = StIdle;
                end else if (rxd_q == Sfd) begin
                    state_d   = StData;
                    len_d     = 16'h0000;
                    crc_d     = CrcInit;
                    er_flag_d = 1'b0;
                    dly_d     = '0;
                end else if (rxd_q != Preamble) begin
                    state_d = StDrop;
                end
            end
            StData: begin
                if (len_q == AbortLen) begin
                    // Oversize frame. The abort is taken one cycle after the last counted byte
                    // so that the byte emitted by that push still goes out.
                    rx_last_d = 1'b1;
                    rx_bad_d  = 1'b1;
                    rx_err_d  = {er_flag_q, 2'b10};
                    rx_len_d  = len_q;
                    state_d   = StDrop;
                end else if (dv_q) begin
                    if (len_q >= 16'd5) begin
                        rx_valid_d = 1'b1;
                        rx_data_d  = dly_q[4];
                    end
                    dly_d = {dly_q[3:0], rxd_q};
                    len_d = len_q + 16'd1;
                    crc_d = crc_byte(crc_q, rxd_q);
                    if (er_q) begin
                        er_flag_d = 1'b1;
                    end
                end else begin
                    if (len_q >= 16'd5) begin
                        rx_valid_d = 1'b1;
                        rx_data_d  = dly_q[4];
                    end
                    rx_last_d = 1'b1;
                    rx_err_d  = end_err;
                    rx_len_d  = len_q;
                    rx_good_d = (end_err == 3'b000);
                    rx_bad_d  = (end_err != 3'b000);
                    state_d   = StIdle;
                end
            end
            StDrop: begin
                if (!dv_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        frames_ok_d  = frames_ok_q;
        frames_bad_d = frames_bad_q;
        if (rx_good_d && (frames_ok_q != 16'hFFFF)) begin
            frames_ok_d = frames_ok_q + 16'd1;
        end
        if (rx_bad_d && (frames_bad_q != 16'hFFFF)) begin
            frames_bad_d = frames_bad_q + 16'd1;
        end
    end

    assign RX_DATA    = rx_data_q;
    assign RX_VALID   = rx_valid_q;
    assign RX_LAST    = rx_last_q;
    assign RX_GOOD    = rx_good_q;
    assign RX_BAD     = rx_bad_q;
    assign RX_ERR     = rx_err_q;
    assign RX_LEN     = rx_len_q;
    assign RX_BUSY    = (state_q != StIdle);
    assign FRAMES_OK  = frames_ok_q;
    assign FRAMES_BAD = frames_bad_q;

endmodule

// File: tb/tb_rx_mac.sv
// Testbench for rx_mac. It uses directed frames with hand-computed expected values.
// Instance u_dut uses MIN_FRAME_LENGTH=13. Instance u_dut64 uses the default of 64 and shares
// the same GMII stimulus.
module tb_rx_mac;

    logic        RX_CLK = 1'b0;
    logic        SYS_RST_N = 1'b0;
    logic [7:0]  GMII_RXD = 8'h00;
    logic        GMII_RX_DV = 1'b0;
    logic        GMII_RX_ER = 1'b0;

    logic [7:0]  RX_DATA;
    logic        RX_VALID, RX_LAST, RX_GOOD, RX_BAD, RX_BUSY;
    logic [2:0]  RX_ERR;
    logic [15:0] RX_LEN, FRAMES_OK, FRAMES_BAD;

    logic [7:0]  b_data;
    logic        b_valid, b_last, b_good, b_bad, b_busy;
    logic [2:0]  b_err;
    logic [15:0] b_len, b_ok, b_badcnt;

    always #4 RX_CLK = ~RX_CLK;

    rx_mac #(.MIN_FRAME_LENGTH(13), .MAX_FRAME_LENGTH(1518)) u_dut (
        .RX_CLK(RX_CLK), .SYS_RST_N(SYS_RST_N),
        .GMII_RXD(GMII_RXD), .GMII_RX_DV(GMII_RX_DV), .GMII_RX_ER(GMII_RX_ER),
        .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_LAST(RX_LAST),
        .RX_GOOD(RX_GOOD), .RX_BAD(RX_BAD), .RX_ERR(RX_ERR), .RX_LEN(RX_LEN),
        .RX_BUSY(RX_BUSY), .FRAMES_OK(FRAMES_OK), .FRAMES_BAD(FRAMES_BAD)
    );

    rx_mac u_dut64 (
        .RX_CLK(RX_CLK), .SYS_RST_N(SYS_RST_N),
        .GMII_RXD(GMII_RXD), .GMII_RX_DV(GMII_RX_DV), .GMII_RX_ER(GMII_RX_ER),
        .RX_DATA(b_data), .RX_VALID(b_valid), .RX_LAST(b_last),
        .RX_GOOD(b_good), .RX_BAD(b_bad), .RX_ERR(b_err), .RX_LEN(b_len),
        .RX_BUSY(b_busy), .FRAMES_OK(b_ok), .FRAMES_BAD(b_badcnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output monitor for both instances, sampled on the falling edge.
    logic [7:0]  rx_bytes[$];
    int          last_count = 0;
    logic [7:0]  last_data = 8'h00;
    logic        last_valid = 1'b0;
    int          stat_count = 0;
    logic        st_good = 1'b0;
    logic        st_bad = 1'b0;
    logic [2:0]  st_err = 3'b000;
    logic [15:0] st_len = 16'h0000;
    int          both_count = 0;
    int          b_stat_count = 0;
    logic        b_st_bad = 1'b0;
    logic [2:0]  b_st_err = 3'b000;
    logic [15:0] b_st_len = 16'h0000;

    always @(negedge RX_CLK) begin
        if (RX_VALID) rx_bytes.push_back(RX_DATA);
        if (RX_LAST) begin
            last_count <= last_count + 1;
            last_data  <= RX_DATA;
            last_valid <= RX_VALID;
        end
        if (RX_GOOD || RX_BAD) begin
            stat_count <= stat_count + 1;
            st_good    <= RX_GOOD;
            st_bad     <= RX_BAD;
            st_err     <= RX_ERR;
            st_len     <= RX_LEN;
        end
        if (RX_GOOD && RX_BAD) both_count <= both_count + 1;
        if (b_good || b_bad) begin
            b_stat_count <= b_stat_count + 1;
            b_st_bad     <= b_bad;
            b_st_err     <= b_err;
            b_st_len     <= b_len;
        end
    end

    logic [7:0] pay[$];

    task automatic drive(input logic [7:0] d, input logic dv, input logic er);
        @(negedge RX_CLK);
        GMII_RXD   = d;
        GMII_RX_DV = dv;
        GMII_RX_ER = er;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(8'h00, 1'b0, 1'b0);
        #1;
    endtask

    task automatic preamble_sfd();
        repeat (7) drive(8'h55, 1'b1, 1'b0);
        drive(8'hD5, 1'b1, 1'b0);
    endtask

    task automatic send_frame(input int er_idx);
        preamble_sfd();
        for (int i = 0; i < pay.size(); i++) drive(pay[i], 1'b1, (i == er_idx));
        idle(4);
    endtask

    // "123456789" followed by its FCS; a last FCS byte of 0xCB gives a correct CRC.
    task automatic load_good(input logic [7:0] fcs3);
        pay = {};
        for (int i = 0; i < 9; i++) pay.push_back(8'h31 + 8'(i));
        pay.push_back(8'h26);
        pay.push_back(8'h39);
        pay.push_back(8'hF4);
        pay.push_back(fcs3);
    endtask

    task automatic check_stream9(input string tag, input int s);
        check_eq({tag, "_nbytes"}, rx_bytes.size() - s, 9);
        for (int i = 0; i < 9; i++) check_eq({tag, "_data"}, rx_bytes[s + i], 8'h31 + 8'(i));
    endtask

    int s, sc, lc, bsc, mism;

    initial begin
        // Reset
        idle(3);
        check_eq("rst_valid", RX_VALID, 0);
        check_eq("rst_last", RX_LAST, 0);
        check_eq("rst_good", RX_GOOD, 0);
        check_eq("rst_bad", RX_BAD, 0);
        check_eq("rst_busy", RX_BUSY, 0);
        check_eq("rst_len", RX_LEN, 0);
        check_eq("rst_ok", FRAMES_OK, 0);
        check_eq("rst_badcnt", FRAMES_BAD, 0);
        SYS_RST_N = 1'b1;
        idle(3);

        // Good frame
        load_good(8'hCB);
        s = rx_bytes.size(); sc = stat_count; lc = last_count; bsc = b_stat_count;
        send_frame(-1);
        check_stream9("good", s);
        check_eq("good_last_n", last_count - lc, 1);
        check_eq("good_last_data", last_data, 8'h39);
        check_eq("good_last_valid", last_valid, 1);
        check_eq("good_nstat", stat_count - sc, 1);
        check_eq("good_good", st_good, 1);
        check_eq("good_err", st_err, 3'b000);
        check_eq("good_len", st_len, 13);
        check_eq("good_ok", FRAMES_OK, 1);
        check_eq("min64_nstat", b_stat_count - bsc, 1);
        check_eq("min64_bad", b_st_bad, 1);
        check_eq("min64_err", b_st_err, 3'b010);
        check_eq("min64_len", b_st_len, 13);

        // Corrupted FCS
        load_good(8'hCA);
        s = rx_bytes.size(); sc = stat_count;
        send_frame(-1);
        check_stream9("crc", s);
        check_eq("crc_nstat", stat_count - sc, 1);
        check_eq("crc_bad", st_bad, 1);
        check_eq("crc_err", st_err, 3'b001);
        check_eq("crc_badcnt", FRAMES_BAD, 1);
        check_eq("crc_min64_err", b_st_err, 3'b011);

        // 3-byte runt
        pay = {8'h01, 8'h02, 8'h03};
        s = rx_bytes.size(); sc = stat_count; lc = last_count;
        send_frame(-1);
        check_eq("runt_nbytes", rx_bytes.size() - s, 0);
        check_eq("runt_last_n", last_count - lc, 1);
        check_eq("runt_last_valid", last_valid, 0);
        check_eq("runt_bad", st_bad, 1);
        check_eq("runt_err", st_err, 3'b011);
        check_eq("runt_len", st_len, 3);

        // Oversize frame: 1600 bytes after the SFD
        pay = {};
        for (int i = 0; i < 1600; i++) pay.push_back(8'(i));
        s = rx_bytes.size(); sc = stat_count; lc = last_count;
        send_frame(-1);
        check_eq("long_nbytes", rx_bytes.size() - s, 1514);
        mism = 0;
        for (int i = 0; i < 1514; i++) if (rx_bytes[s + i] !== 8'(i)) mism++;
        check_eq("long_data_mism", mism, 0);
        check_eq("long_nstat", stat_count - sc, 1);
        check_eq("long_last_n", last_count - lc, 1);
        check_eq("long_last_valid", last_valid, 0);
        check_eq("long_bad", st_bad, 1);
        check_eq("long_err", st_err, 3'b010);
        check_eq("long_len", st_len, 1519);
        check_eq("long_badcnt", FRAMES_BAD, 3);

        // Next frame after the abort is received normally
        load_good(8'hCB);
        s = rx_bytes.size();
        send_frame(-1);
        check_stream9("after_long", s);
        check_eq("after_long_good", st_good, 1);
        check_eq("after_long_ok", FRAMES_OK, 2);

        // GMII_RX_ER on one payload byte
        load_good(8'hCB);
        sc = stat_count;
        send_frame(4);
        check_eq("er_nstat", stat_count - sc, 1);
        check_eq("er_bad", st_bad, 1);
        check_eq("er_err", st_err, 3'b100);
        check_eq("er_len", st_len, 13);

        // Broken preamble
        s = rx_bytes.size(); sc = stat_count; bsc = b_stat_count;
        drive(8'h55, 1'b1, 1'b0);
        drive(8'h55, 1'b1, 1'b0);
        drive(8'hAA, 1'b1, 1'b0);
        drive(8'hD5, 1'b1, 1'b0);
        drive(8'h31, 1'b1, 1'b0);
        drive(8'h32, 1'b1, 1'b0);
        idle(4);
        check_eq("drop_nbytes", rx_bytes.size() - s, 0);
        check_eq("drop_nstat", stat_count - sc, 0);
        check_eq("drop_min64_nstat", b_stat_count - bsc, 0);

        // Reset in the middle of the payload
        load_good(8'hCB);
        sc = stat_count;
        preamble_sfd();
        for (int i = 0; i < 8; i++) drive(pay[i], 1'b1, 1'b0);
        SYS_RST_N = 1'b0;
        #1;
        check_eq("mrst_valid", RX_VALID, 0);
        check_eq("mrst_data", RX_DATA, 0);
        check_eq("mrst_busy", RX_BUSY, 0);
        check_eq("mrst_len", RX_LEN, 0);
        check_eq("mrst_ok", FRAMES_OK, 0);
        check_eq("mrst_badcnt", FRAMES_BAD, 0);
        drive(pay[8], 1'b1, 1'b0);
        SYS_RST_N = 1'b1;
        for (int i = 9; i < 13; i++) drive(pay[i], 1'b1, 1'b0);
        idle(4);
        check_eq("mrst_nstat", stat_count - sc, 0);
        s = rx_bytes.size(); sc = stat_count;
        send_frame(-1);
        check_stream9("post_rst", s);
        check_eq("post_rst_nstat", stat_count - sc, 1);
        check_eq("post_rst_good", st_good, 1);
        check_eq("post_rst_ok", FRAMES_OK, 1);
        check_eq("post_rst_badcnt", FRAMES_BAD, 0);

        check_eq("good_bad_together", both_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rx_mac.md
# rx_mac

Receive-side MAC for the 1G Ethernet path. It consumes an 8-bit GMII stream from the PHY, or a loop-back of the transmit MAC output, and strips the preamble and SFD. It forwards the frame body minus the FCS as a byte stream with valid/last, checks the CRC-32 and length, and reports per-frame status plus saturating good/bad frame counters.

## Interface
- MIN_FRAME_LENGTH, 64: minimum legal length in bytes, counted from the first byte after SFD through the last FCS byte.
- MAX_FRAME_LENGTH, 1518: maximum legal length, counted the same way; must be ≤ 65534.
- RX_CLK  in  1  receive clock, 125 MHz, all logic on rising edge.
- SYS_RST_N  in  1  reset, asynchronous assert, active-low (fixed).
- GMII_RXD  in  8  GMII receive data.
- GMII_RX_DV  in  1  GMII data valid; frame delimiter.
- GMII_RX_ER  in  1  GMII receive error.
- RX_DATA  out  8  frame byte, FCS excluded.
- RX_VALID  out  1  RX_DATA valid, one byte per cycle, no backpressure.
- RX_LAST  out  1  frame termination; normally with RX_VALID on the final non-FCS byte.
- RX_GOOD  out  1  one-cycle pulse: frame passed all checks.
- RX_BAD  out  1  one-cycle pulse: frame failed.
- RX_ERR  out  3  valid with RX_GOOD/RX_BAD: [0] CRC, [1] length (runt or too long), [2] GMII_RX_ER seen.
- RX_LEN  out  16  byte count, SFD excluded, FCS included; valid with RX_GOOD/RX_BAD.
- RX_BUSY  out  1  high in states PREAMBLE, DATA, DROP.
- FRAMES_OK  out  16  saturating count of RX_GOOD pulses.
- FRAMES_BAD  out  16  saturating count of RX_BAD pulses.

## Operation
- Input stage: GMII_RXD, GMII_RX_DV and GMII_RX_ER are registered once before the FSM. "DV", "D" and "ER" below mean the registered values.
- FSM states: IDLE, PREAMBLE, DATA, DROP.
- IDLE
  - DV=1 and D=0x55 → PREAMBLE.
  - DV=1 with any other byte, including 0xD5 → DROP.
  - DV=0 → stay.
- PREAMBLE
  - D=0x55 → stay; no upper limit on preamble length.
  - D=0xD5 → DATA, and clear length, CRC, delay line and error flags.
  - DV=0 → IDLE.
  - Any other byte → DROP.
  - No status pulse on any exit from PREAMBLE.
- DATA, each cycle with DV=1:
  - Push D into a 5-byte delay line.
  - If all 5 slots were already full, emit the oldest byte with RX_VALID=1.
  - RX_LEN counter +1.
  - CRC register updated with D.
  - ER=1 sets the sticky flag for RX_ERR[2].
- CRC: reflected CRC-32, polynomial 0xEDB88320, register init 0xFFFFFFFF, LSB of each byte first. It is updated over every DATA byte including the 4 FCS bytes. The CRC is good iff the register equals residue 0xDEBB20E3.
- DATA, DV=0 (normal end), all in one cycle:
  - If length ≥ 5: emit the oldest slot with RX_VALID=1 and RX_LAST=1. The remaining 4 slots are the FCS and are discarded.
  - If length < 5: RX_LAST=1 with RX_VALID=0.
  - Pulse RX_GOOD or RX_BAD, with RX_LEN = final count.
  - RX_ERR[0] = CRC mismatch; RX_ERR[1] = length < MIN_FRAME_LENGTH; RX_ERR[2] = ER flag.
  - RX_GOOD iff RX_ERR == 0.
  - → IDLE.
- DATA, count reaching MAX_FRAME_LENGTH+1 (abort):
  - RX_LAST=1, RX_VALID=0, RX_BAD with RX_ERR[1]=1 and RX_ERR[0]=0.
  - RX_LEN = MAX_FRAME_LENGTH+1; other bits per flags.
  - → DROP.
- DROP: no outputs; DV=0 → IDLE.
- Counters: FRAMES_OK / FRAMES_BAD +1 on the same edge as the pulse; hold at 0xFFFF.

## Timing
- Reset (async, SYS_RST_N=0): all outputs 0, counters 0, state IDLE, delay line cleared. A frame in progress is discarded with no status pulse. Reception resumes at the next preamble after reset release.
- Data latency: byte k sampled from GMII at edge n is pushed at edge n+1. Byte k-5 appears on RX_DATA after edge n+1.
- End latency: DV=0 sampled at edge m → RX_LAST, status, RX_LEN and counter update all visible after edge m+1.
- A new frame may start on the cycle immediately after DV falls. IDLE samples it with no dead cycle, provided the previous frame ended via DATA→IDLE.
- RX_VALID is never high in IDLE, PREAMBLE or DROP. RX_GOOD and RX_BAD are never high together.

## Test plan
- Good frame, MIN_FRAME_LENGTH=13: 7×0x55, 0xD5, ASCII "123456789" (0x31..0x39), FCS 0x26 0x39 0xF4 0xCB, DV low → 9 RX_VALID bytes 0x31..0x39, RX_LAST on 0x39, RX_GOOD=1, RX_ERR=000, RX_LEN=13, FRAMES_OK=1.
- Same frame with last FCS byte 0xCA → identical data stream, RX_BAD=1, RX_ERR=001, FRAMES_BAD=1.
- Same correct frame with default MIN_FRAME_LENGTH=64 → RX_BAD, RX_ERR=010, RX_LEN=13. Plus a 3-byte frame → RX_LAST with RX_VALID=0, RX_BAD, RX_LEN=3.
- DV held 1600 bytes after SFD, MAX_FRAME_LENGTH=1518 → 1514 valid bytes; abort RX_BAD, RX_ERR[1]=1, RX_LEN=1519; no further RX_VALID until the next preamble, which is then received as good.
- GMII_RX_ER=1 for one byte mid-payload of a good frame → RX_BAD, RX_ERR=100. Separately, preamble 0x55 0x55 0xAA → DROP, no status pulse, no RX_VALID.
- SYS_RST_N low for 1 cycle mid-payload → all outputs 0 immediately, counters 0; the following good frame yields RX_GOOD and FRAMES_OK=1.
